// File: rtl/aes_v3_pkg.sv
// aes_v3_pkg: shared FSM encodings and GF(2^8) helpers for the AES v3 iterative unit.
package aes_v3_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Only power-of-two lane counts that divide a 4-byte column are supported.
    function automatic logic lanes_legal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4);
    endfunction

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply; constant operands fold down to a few XORs.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 = product of x^(2^k) for k = 1..7; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // MixColumn coefficient k of the circulant row (forward 02 03 01 01, inverse 0e 0b 0d 09).
    function automatic logic [7:0] mix_coef(input logic enc, input int k);
        logic [7:0] c;
        case (k)
            0:       c = enc ? 8'h02 : 8'h0E;
            1:       c = enc ? 8'h03 : 8'h0B;
            2:       c = enc ? 8'h01 : 8'h0D;
            default: c = enc ? 8'h01 : 8'h09;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aes_v3_sbox.sv
// aes_v3_sbox: combinational forward / inverse AES S-box built from GF inverse and affine map.
module aes_v3_sbox (
    input  logic [7:0] din,
    input  logic       enc,
    output logic [7:0] dout
);
    import aes_v3_pkg::*;

    logic [7:0] pre;
    logic [7:0] inv;

    // Forward affine transform: b = x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    // Inverse affine transform: x = rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
    function automatic logic [7:0] inv_affine(input logic [7:0] y);
        return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    endfunction

    // One shared inverter: forward applies the affine map after it, inverse undoes it before.
    always_comb begin
        pre  = enc ? din : inv_affine(din);
        inv  = gf_inv(pre);
        dout = enc ? affine(inv) : inv;
    end

endmodule

// File: rtl/aes_v3_iter.sv
// aes_v3_iter: multi-cycle AES SubWord / MixColumn unit; LANES S-boxes process a column in 4/LANES cycles.
module aes_v3_iter #(
    parameter int LANES    = 4,
    parameter bit FUSE_ARK = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        valid,
    input  logic        sub,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    input  logic        rot,
    output logic        ready,
    output logic [31:0] rd
);
    import aes_v3_pkg::*;

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("aes_v3_iter: LANES must be 1, 2 or 4");
    end

    localparam logic [1:0] LANE_STEP = 2'(LANES);
    localparam logic [1:0] LAST_CNT  = 2'(4 - LANES);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] w_q, w_d;
    logic [31:0] res_q, res_d;
    logic        enc_q, enc_d;
    logic        rot_q, rot_d;
    logic        ready_q, ready_d;

    logic        busy;
    logic [31:0] lane_word;
    logic [1:0]  lane_base;
    logic        lane_enc;
    logic        lane_rot;
    logic [7:0]  lane_in  [LANES];
    logic [7:0]  lane_out [LANES];
    logic [31:0] sub_word;
    logic [31:0] sub_final;
    logic [31:0] mix_word;

    assign busy = (state_q == ST_BUSY);

    // The accept cycle already does the first byte group from the raw operands; BUSY uses latched copies.
    always_comb begin
        lane_word = busy ? w_q   : {rs1[31:16], rs2[15:0]};
        lane_base = busy ? cnt_q : 2'd0;
        lane_enc  = busy ? enc_q : enc;
        lane_rot  = busy ? rot_q : rot;
        for (int j = 0; j < LANES; j++) begin
            lane_in[j] = lane_word[{lane_base + 2'(j), 3'b000} +: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_v3_sbox u_sbox (
            .din  (lane_in[g]),
            .enc  (lane_enc),
            .dout (lane_out[g])
        );
    end

    // Merge this cycle's substituted bytes into the partial result; rotation only touches the finished word.
    always_comb begin
        sub_word = busy ? res_q : lane_word;
        for (int j = 0; j < LANES; j++) begin
            sub_word[{lane_base + 2'(j), 3'b000} +: 8] = lane_out[j];
        end
        sub_final = lane_rot ? {sub_word[7:0], sub_word[31:8]} : sub_word;
    end

    // Single-stage MixColumn on the presented column, with optional fused round-key XOR.
    always_comb begin
        mix_word = '0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                mix_word[8*i +: 8] = mix_word[8*i +: 8] ^ gf_mul(mix_coef(enc, k), rs1[8*((i + k) % 4) +: 8]);
            end
        end
        if (FUSE_ARK) mix_word = mix_word ^ rs2;
    end

    // Next-state logic for the IDLE / BUSY / DONE sequencer and its operand and result registers.
    always_comb begin
        // NOTE: every signal gets a hold default before the case so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        res_d   = res_q;
        enc_d   = enc_q;
        rot_d   = rot_q;
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    enc_d = enc;
                    rot_d = rot;
                    w_d   = lane_word;
                    if (!sub) begin
                        res_d   = mix_word;
                        state_d = ST_DONE;
                    end else if (LANES == 4) begin
                        res_d   = sub_final;
                        state_d = ST_DONE;
                    end else begin
                        res_d   = sub_word;
                        cnt_d   = LANE_STEP;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (!valid) begin
                    // Abort: drop the op, keep the partial result, never pulse ready.
                    cnt_d   = 2'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    res_d   = sub_final;
                    cnt_d   = 2'd0;
                    state_d = ST_DONE;
                end else begin
                    res_d = sub_word;
                    cnt_d = cnt_q + LANE_STEP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_DONE);
    end

    // State, counter, operand and result registers; reset discards any op in flight.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        // NOTE: non-blocking assignments so all flops update together from pre-edge values.
        if (!g_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            w_q     <= '0;
            res_q   <= '0;
            enc_q   <= 1'b0;
            rot_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            res_q   <= res_d;
            enc_q   <= enc_d;
            rot_q   <= rot_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign rd    = res_q;

endmodule

// File: tb/tb_aes_v3_iter.sv
// tb_aes_v3_iter: drives four instances (LANES 1/2/4 fused, LANES 2 unfused) against a table-based AES model.
module tb_aes_v3_iter;

    localparam int NI = 4;
    localparam int LANES_OF [NI] = '{1, 2, 4, 2};
    localparam bit FUSE_OF  [NI] = '{1'b1, 1'b1, 1'b1, 1'b0};

    logic                 g_clk;
    logic                 g_resetn;
    logic [NI-1:0]        valid_v, sub_v, enc_v, rot_v, ready_v;
    logic [NI-1:0][31:0]  rs1_v, rs2_v, rd_v;
    logic [NI-1:0]        ready_prev;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_v3_iter #(.LANES(LANES_OF[g]), .FUSE_ARK(FUSE_OF[g])) u_dut (
            .g_clk    (g_clk),
            .g_resetn (g_resetn),
            .valid    (valid_v[g]),
            .sub      (sub_v[g]),
            .rs1      (rs1_v[g]),
            .rs2      (rs2_v[g]),
            .enc      (enc_v[g]),
            .rot      (rot_v[g]),
            .ready    (ready_v[g]),
            .rd       (rd_v[g])
        );
    end

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ready must be a single-cycle pulse on every instance.
    initial ready_prev = '0;
    always @(negedge g_clk) begin
        for (int i = 0; i < NI; i++) begin
            if (ready_v[i]) begin
                n_cmp++;
                if (ready_prev[i]) begin
                    n_bad++;
                    $display("FAIL ready_pulse inst=%0d got=two consecutive ready cycles exp=single pulse", i);
                end
            end
        end
        ready_prev = ready_v;
    end

    // ---------------- reference model ----------------

    // Carry-less product then long division by 0x11B.
    function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int t = 14; t >= 8; t--) if (p[t]) p = p ^ (15'h11B << (t - 8));
        return p[7:0];
    endfunction

    // Forward S-box by brute-force inverse search and bitwise affine map; inverse table by inversion.
    task automatic build_tables();
        logic [7:0] c;
        logic [7:0] xi;
        logic [7:0] y;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            xi = 8'h00;
            for (int z = 1; z < 256; z++) if (ref_gmul(8'(x), 8'(z)) == 8'h01) xi = 8'(z);
            for (int t = 0; t < 8; t++)
                y[t] = xi[t] ^ xi[(t + 4) % 8] ^ xi[(t + 5) % 8] ^ xi[(t + 6) % 8] ^ xi[(t + 7) % 8] ^ c[t];
            sbox_t[x]  = y;
            isbox_t[y] = 8'(x);
        end
    endtask

    function automatic logic [31:0] ref_result(input int i, input logic s, input logic e, input logic r,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] w;
        logic [31:0] res;
        logic [7:0]  cf [4];
        res = '0;
        if (s) begin
            w = {a[31:16], b[15:0]};
            for (int k = 0; k < 4; k++) res[8*k +: 8] = e ? sbox_t[w[8*k +: 8]] : isbox_t[w[8*k +: 8]];
            if (r) res = {res[7:0], res[31:8]};
        end else begin
            if (e) cf = '{8'h02, 8'h03, 8'h01, 8'h01};
            else   cf = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
            for (int o = 0; o < 4; o++)
                for (int k = 0; k < 4; k++)
                    res[8*o +: 8] = res[8*o +: 8] ^ ref_gmul(cf[k], a[8*((o + k) % 4) +: 8]);
            if (FUSE_OF[i]) res = res ^ b;
        end
        return res;
    endfunction

    function automatic int exp_lat(input int i, input logic s);
        return s ? 4 / LANES_OF[i] : 1;
    endfunction

    // Issue one request from an IDLE cycle; scramble operands after acceptance; return latency and rd.
    task automatic do_op(input int i, input logic s, input logic e, input logic r,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] got);
        valid_v[i] = 1'b1; sub_v[i] = s; enc_v[i] = e; rot_v[i] = r; rs1_v[i] = a; rs2_v[i] = b;
        lat = -1;
        got = '0;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge g_clk);
            sub_v[i] = 1'($urandom); enc_v[i] = 1'($urandom); rot_v[i] = 1'($urandom);
            rs1_v[i] = $urandom;     rs2_v[i] = $urandom;
            if (ready_v[i]) begin
                lat = c;
                got = rd_v[i];
            end
        end
        valid_v[i] = 1'b0;
        @(negedge g_clk);
    endtask

    // ---------------- scenarios ----------------

    task automatic test_reset();
        g_resetn = 1'b1;
        #1 g_resetn = 1'b0;
        #2;
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (ready_v[i] !== 1'b0) begin n_bad++; $display("FAIL reset_ready inst=%0d got=%b exp=0", i, ready_v[i]); end
            n_cmp++;
            if (rd_v[i] !== 32'h0) begin n_bad++; $display("FAIL reset_rd inst=%0d got=%h exp=00000000", i, rd_v[i]); end
        end
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(negedge g_clk);
    endtask

    task automatic test_sub_vectors();
        logic [31:0] t_rs1 [3] = '{32'h53530000, 32'h53530000, 32'h63636363};
        logic [31:0] t_rs2 [3] = '{32'h00000000, 32'h00000000, 32'h63636363};
        logic        t_enc [3] = '{1'b1, 1'b1, 1'b0};
        logic        t_rot [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] t_exp [3] = '{32'hEDED6363, 32'h63EDED63, 32'h00000000};
        int lat;
        logic [31:0] got;
        for (int i = 0; i < NI; i++) begin
            for (int v = 0; v < 3; v++) begin
                do_op(i, 1'b1, t_enc[v], t_rot[v], t_rs1[v], t_rs2[v], lat, got);
                n_cmp++;
                if (lat !== 4 / LANES_OF[i]) begin n_bad++; $display("FAIL sub_lat inst=%0d vec=%0d got=%0d exp=%0d", i, v, lat, 4 / LANES_OF[i]); end
                n_cmp++;
                if (got !== t_exp[v]) begin n_bad++; $display("FAIL sub_rd inst=%0d vec=%0d got=%h exp=%h", i, v, got, t_exp[v]); end
            end
        end
    endtask

    task automatic test_mix_vectors();
        logic [31:0] t_rs1 [3] = '{32'h455313DB, 32'h455313DB, 32'hBCA14D8E};
        logic [31:0] t_rs2 [3] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000};
        logic        t_enc [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] t_mix [3] = '{32'hBCA14D8E, 32'hBCA14D8E, 32'h455313DB};
        logic [31:0] exp;
        int lat;
        logic [31:0] got;
        for (int i = 0; i < NI; i++) begin
            for (int v = 0; v < 3; v++) begin
                exp = FUSE_OF[i] ? (t_mix[v] ^ t_rs2[v]) : t_mix[v];
                do_op(i, 1'b0, t_enc[v], 1'b1, t_rs1[v], t_rs2[v], lat, got);
                n_cmp++;
                if (lat !== 1) begin n_bad++; $display("FAIL mix_lat inst=%0d vec=%0d got=%0d exp=1", i, v, lat); end
                n_cmp++;
                if (got !== exp) begin n_bad++; $display("FAIL mix_rd inst=%0d vec=%0d got=%h exp=%h", i, v, got, exp); end
            end
        end
    endtask

    task automatic test_abort();
        int seen;
        int lat;
        logic [31:0] got;
        seen = 0;
        valid_v[0] = 1'b1; sub_v[0] = 1'b1; enc_v[0] = 1'b1; rot_v[0] = 1'b0;
        rs1_v[0] = 32'h53530000; rs2_v[0] = 32'h0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge g_clk);
            if (ready_v[0]) seen++;
            if (c == 2) valid_v[0] = 1'b0;
        end
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("FAIL abort_ready got=%0d pulses exp=0", seen); end
        do_op(0, 1'b1, 1'b1, 1'b1, 32'h53530000, 32'h0, lat, got);
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL abort_next_lat got=%0d exp=4", lat); end
        n_cmp++;
        if (got !== 32'h63EDED63) begin n_bad++; $display("FAIL abort_next_rd got=%h exp=63EDED63", got); end
    endtask

    task automatic test_reset_midop();
        int seen;
        seen = 0;
        valid_v[0] = 1'b1; sub_v[0] = 1'b1; enc_v[0] = 1'b1; rot_v[0] = 1'b0;
        rs1_v[0] = 32'h53530000; rs2_v[0] = 32'h0;
        @(negedge g_clk);
        @(negedge g_clk);
        g_resetn = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (ready_v[i] !== 1'b0) begin n_bad++; $display("FAIL midrst_ready inst=%0d got=%b exp=0", i, ready_v[i]); end
            n_cmp++;
            if (rd_v[i] !== 32'h0) begin n_bad++; $display("FAIL midrst_rd inst=%0d got=%h exp=00000000", i, rd_v[i]); end
        end
        valid_v[0] = 1'b0;
        @(negedge g_clk);
        g_resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge g_clk);
            if (ready_v != '0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("FAIL midrst_no_ready got=%0d pulses exp=0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, exp_a, exp_b, got;
        logic        e1, r1, s2, e2, r2;
        int lat;
        for (int i = 0; i < NI; i++) begin
            a1 = $urandom; b1 = $urandom; e1 = 1'($urandom); r1 = 1'($urandom);
            a2 = $urandom; b2 = $urandom; s2 = 1'($urandom); e2 = 1'($urandom); r2 = 1'($urandom);
            exp_a = ref_result(i, 1'b1, e1, r1, a1, b1);
            exp_b = ref_result(i, s2, e2, r2, a2, b2);
            valid_v[i] = 1'b1; sub_v[i] = 1'b1; enc_v[i] = e1; rot_v[i] = r1; rs1_v[i] = a1; rs2_v[i] = b1;
            lat = -1; got = '0;
            for (int c = 1; c <= 8 && lat < 0; c++) begin
                @(negedge g_clk);
                if (ready_v[i]) begin lat = c; got = rd_v[i]; end
            end
            n_cmp++;
            if (lat !== exp_lat(i, 1'b1)) begin n_bad++; $display("FAIL b2b_lat_a inst=%0d got=%0d exp=%0d", i, lat, exp_lat(i, 1'b1)); end
            n_cmp++;
            if (got !== exp_a) begin n_bad++; $display("FAIL b2b_rd_a inst=%0d got=%h exp=%h", i, got, exp_a); end
            // valid stays high through DONE; the requester re-presents the next operands
            sub_v[i] = s2; enc_v[i] = e2; rot_v[i] = r2; rs1_v[i] = a2; rs2_v[i] = b2;
            lat = -1; got = '0;
            for (int c = 1; c <= 8 && lat < 0; c++) begin
                @(negedge g_clk);
                if (ready_v[i]) begin lat = c; got = rd_v[i]; end
            end
            valid_v[i] = 1'b0;
            @(negedge g_clk);
            n_cmp++;
            if (lat !== 1 + exp_lat(i, s2)) begin n_bad++; $display("FAIL b2b_lat_b inst=%0d got=%0d exp=%0d", i, lat, 1 + exp_lat(i, s2)); end
            n_cmp++;
            if (got !== exp_b) begin n_bad++; $display("FAIL b2b_rd_b inst=%0d got=%h exp=%h", i, got, exp_b); end
        end
    endtask

    task automatic test_random();
        logic        s, e, r;
        logic [31:0] a, b, exp, got;
        int lat, n, k, seen;
        for (int i = 0; i < NI; i++) begin
            for (int op = 0; op < 2500; op++) begin
                repeat ($urandom_range(0, 2)) @(negedge g_clk);
                s = 1'($urandom); e = 1'($urandom); r = 1'($urandom); a = $urandom; b = $urandom;
                n = exp_lat(i, s);
                if (s && n > 1 && $urandom_range(0, 7) == 0) begin
                    k = $urandom_range(1, n - 1);
                    seen = 0;
                    valid_v[i] = 1'b1; sub_v[i] = s; enc_v[i] = e; rot_v[i] = r; rs1_v[i] = a; rs2_v[i] = b;
                    for (int c = 1; c <= k + 1; c++) begin
                        @(negedge g_clk);
                        if (ready_v[i]) seen++;
                        if (c == k) valid_v[i] = 1'b0;
                    end
                    n_cmp++;
                    if (seen != 0) begin n_bad++; $display("FAIL rand_abort inst=%0d op=%0d got=%0d pulses exp=0", i, op, seen); end
                end else begin
                    exp = ref_result(i, s, e, r, a, b);
                    do_op(i, s, e, r, a, b, lat, got);
                    n_cmp++;
                    if (lat !== n) begin n_bad++; $display("FAIL rand_lat inst=%0d op=%0d got=%0d exp=%0d", i, op, lat, n); end
                    n_cmp++;
                    if (got !== exp) begin n_bad++; $display("FAIL rand_rd inst=%0d op=%0d sub=%b enc=%b rot=%b rs1=%h rs2=%h got=%h exp=%h", i, op, s, e, r, a, b, got, exp); end
                end
            end
        end
    endtask

    initial begin
        g_resetn = 1'b1;
        valid_v = '0; sub_v = '0; enc_v = '0; rot_v = '0;
        rs1_v = '0; rs2_v = '0;
        build_tables();
        test_reset();
        test_sub_vectors();
        test_mix_vectors();
        test_abort();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
